// File: rtl/fpu_result_checker.sv
// Result scoreboard for the FPU regression bench: buffers measured words, compares them
// against an expected stream, and keeps counters, sticky flags and a pass/timeout verdict.
module fpu_result_checker #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned NAN_EQUIV      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  measValidIn,
  input  logic [DATA_WIDTH-1:0] measDataIn,
  input  logic                  expValidIn,
  input  logic [DATA_WIDTH-1:0] expDataIn,
  input  logic                  expDoneIn,
  output logic                  expAdvanceOut,
  output logic [CNT_WIDTH-1:0]  matchCountOut,
  output logic [CNT_WIDTH-1:0]  errCountOut,
  output logic [CNT_WIDTH-1:0]  firstErrIdxOut,
  output logic                  overflowOut,
  output logic                  extraOut,
  output logic                  doneOut,
  output logic                  passOut,
  output logic                  timeoutOut
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EXP_W = (DATA_WIDTH == 64) ? 11 : ((DATA_WIDTH == 16) ? 5 : 8);
  localparam int unsigned MAN_W = DATA_WIDTH - 1 - EXP_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t state_q, state_n;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  empty, full, active;
  logic                  meas_req, push, pop, drop;
  logic [DATA_WIDTH-1:0] head;
  logic                  match_c;

  logic                  cmp_vld, cmp_match, cmp_extra;
  logic [CNT_WIDTH-1:0]  cmp_idx, idx_cnt;
  logic                  first_seen;
  logic [TMR_W-1:0]      timer;
  logic [CNT_WIDTH-1:0]  err_n;
  logic [CNT_WIDTH+1:0]  err_sum;
  logic [1:0]            err_inc;
  logic                  mism;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] w);
    return (&w[DATA_WIDTH-2 -: EXP_W]) && (|w[MAN_W-1:0]);
  endfunction

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign active = (state_q == IDLE) || (state_q == RUN);

  assign meas_req = measValidIn && active;
  assign pop      = active && !empty && (expValidIn || expDoneIn);
  assign push     = meas_req && (!full || pop);
  assign drop     = meas_req && full && !pop;

  assign expAdvanceOut = pop && expValidIn && !expDoneIn;

  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign match_c = (head == expDataIn) ||
                   ((NAN_EQUIV != 0) && is_nan(head) && is_nan(expDataIn));

  // Measured-word buffer storage
  always_ff @(posedge clkIn) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= measDataIn;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Compare stage: result is applied to the counters one cycle after the pop
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      cmp_vld   <= 1'b0;
      cmp_match <= 1'b0;
      cmp_extra <= 1'b0;
      cmp_idx   <= '0;
      idx_cnt   <= '0;
    end else begin
      cmp_vld   <= pop;
      cmp_match <= !expDoneIn && match_c;
      cmp_extra <= expDoneIn;
      cmp_idx   <= idx_cnt;
      if (pop && idx_cnt != CNT_MAX) idx_cnt <= idx_cnt + CNT_WIDTH'(1);
    end
  end

  // A drop and a failed compare can land in the same cycle, so errors may step by two
  assign mism    = cmp_vld && !cmp_extra && !cmp_match;
  assign err_inc = 2'(cmp_vld && !cmp_match) + 2'(drop);
  assign err_sum = (CNT_WIDTH+2)'(errCountOut) + (CNT_WIDTH+2)'(err_inc);
  assign err_n   = (err_sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) ? CNT_MAX : err_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      matchCountOut  <= '0;
      errCountOut    <= '0;
      firstErrIdxOut <= '0;
      first_seen     <= 1'b0;
      overflowOut    <= 1'b0;
      extraOut       <= 1'b0;
    end else begin
      errCountOut <= err_n;
      if (cmp_vld && cmp_match && matchCountOut != CNT_MAX)
        matchCountOut <= matchCountOut + CNT_WIDTH'(1);
      if (mism && !first_seen) begin
        firstErrIdxOut <= cmp_idx;
        first_seen     <= 1'b1;
      end
      if (drop) overflowOut <= 1'b1;
      if (cmp_vld && cmp_extra) extraOut <= 1'b1;
    end
  end

  // Inactivity timer: cleared by any measurement, counts only while running
  always_ff @(posedge clkIn) begin
    if (rstIn)                timer <= '0;
    else if (meas_req)        timer <= '0;
    else if (state_q == RUN)  timer <= timer + TMR_W'(1);
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q    <= IDLE;
      doneOut    <= 1'b0;
      timeoutOut <= 1'b0;
      passOut    <= 1'b0;
    end else begin
      state_q    <= state_n;
      doneOut    <= (state_n == DONE) || (state_n == TIMEOUT);
      timeoutOut <= (state_n == TIMEOUT);
      passOut    <= (state_n == DONE) && (err_n == '0);
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (push) state_n = RUN;
      RUN: begin
        if (expDoneIn && empty && !cmp_vld && !meas_req)
          state_n = DONE;
        else if (!meas_req && timer == TMR_W'(TIMEOUT_CYCLES - 1))
          state_n = TIMEOUT;
      end
      DONE:    state_n = DONE;
      TIMEOUT: state_n = TIMEOUT;
      default: state_n = IDLE;
    endcase
  end

endmodule
